seg_display_driver: RTL and testbench
=====================================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter CLK_DIV, default 100000, is the number of clk cycles per digit slot; legal values are 8 or more.
REQ-002 Parameter GUARD, default 16, is the number of blanked cycles at the start of each slot; legal values are 1 to CLK_DIV-1.
REQ-003 Parameter BLINK_BITS, default 8, is the width of the frame counter that sets the blink period.
REQ-004 clk  in  1  single clock for the whole block.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 shown16  in  16  value to display as four hex digits.
REQ-007 flags  in  5  ALU status flags.
REQ-008 load  in  1  strobe that latches shown16 and flags into the display buffer.
REQ-009 blank  in  1  forces all digits off while high.
REQ-010 an  out  4  digit anode enables, active-low; an[0] is the rightmost digit.
REQ-011 seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 led  out  5  flag LEDs, active-high.
REQ-014 frame_done  out  1  one-cycle pulse at the end of each full four-digit scan.

Function
REQ-015 On a rising clk edge with load=1, the block SHALL copy shown16 into val_buf and flags into flag_buf.
REQ-016 Slot counter: counts 0 to CLK_DIV-1 and wraps to 0; each wrap advances the digit index 0→1→2→3→0.
REQ-017 Digit k shows val_buf[4k+3:4k].
REQ-018 an, seg, dp and led SHALL be registered, with a latency of one cycle from the counter, index and buffer state.
REQ-019 When the slot counter is below GUARD, an SHALL be 4'b1111; otherwise an SHALL be active-low one-hot on the current index.
REQ-020 Hex decode is standard. Checkpoints: 0→1000000, 1→1111001, 2→0100100, 8→0000000, A→0001000, F→0001110.
REQ-021 dp SHALL be 0 only while digit 0 is enabled and flag_buf is nonzero; otherwise dp=1.
REQ-022 led SHALL equal flag_buf.
REQ-023 frame_done SHALL be 1 for exactly one cycle when the index wraps 3→0. The period is exactly 4*CLK_DIV cycles.
REQ-024 blank=1 forces an=4'b1111 in the next cycle. The counters, frame_done and led are unaffected.
REQ-025 If load coincides with a slot wrap, the newly entered digit SHALL show the new buffer contents.
REQ-026 If load is held high, the buffer SHALL be updated on every cycle.

Reset
REQ-027 While reset=0, asynchronously: an=4'b1111, seg=7'b1111111, dp=1, led=0, frame_done=0.
REQ-028 While reset=0: val_buf=0, flag_buf=0, slot counter=0, digit index=0, frame counter=0.
REQ-029 Reset asserted mid-slot SHALL abort the scan; after release, scanning restarts at digit 0, slot count 0.

Configuration
REQ-030 Macro SEG_FLAG_BLINK_EN enables flag blinking.
REQ-031 With SEG_FLAG_BLINK_EN defined, a BLINK_BITS-bit frame counter SHALL increment on each frame_done.
REQ-032 With SEG_FLAG_BLINK_EN defined, while flag_buf is nonzero and the counter MSB is 1, an SHALL be forced to 4'b1111.
REQ-033 With SEG_FLAG_BLINK_EN undefined, the frame counter SHALL NOT exist and the display SHALL never blink.
REQ-034 led and dp SHALL behave the same with and without SEG_FLAG_BLINK_EN.

Structure
REQ-035 Shared package seg_pkg SHALL hold: the SEG_OFF=7'b1111111 constant, the AN_OFF=4'b1111 constant, the 2-bit digit-index type, and the hex-to-segment table.
REQ-036 The hex decode SHALL be a separate combinational sub-module hex_to_7seg (4-bit in, 7-bit out). The scan FSM and the registers stay in seg_display_driver.

Verification
All scenarios use CLK_DIV=8, GUARD=2, BLINK_BITS=2.
REQ-037 Reset: hold reset=0 for 3 cycles → an=1111, seg=1111111, led=00000. After release, an=1110 at slot count 2, with one cycle of latency.
REQ-038 Decode: load shown16=16'h12AF, flags=0. Digit 0 → an=1110, seg=0001110. Digit 1 → an=1101, seg=0001000. Digit 2 → seg=0100100. Digit 3 → an=0111, seg=1111001. dp=1 throughout.
REQ-039 Timing: frame_done pulses every 32 cycles and is high for one cycle. In each 8-cycle slot, an=1111 for the first 2 cycles.
REQ-040 Blank: raise blank mid-digit-1 → an=1111 on the next cycle. frame_done period remains 32. On release, scanning resumes at the correct digit.
REQ-041 Boundary: pulse load with shown16=16'h000F exactly on the 3→0 wrap cycle. Digit 0 of the new frame → seg=0001110.
REQ-042 Flags: load flags=5'b00001 → led=00001, dp=0 only during digit 0. With SEG_FLAG_BLINK_EN, an=1111 during frames 2–3 of each 4-frame cycle. Without the macro, there is no blanking.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, types and the hex-to-segment table for the seven-segment
// display driver. Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Index is the hex nibble; entry 0 is the leftmost element.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

endpackage

// File: rtl/seg_display_driver_hex.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with flag LEDs.
// Each digit slot lasts CLK_DIV cycles; the first GUARD cycles of a slot keep
// all anodes off to avoid ghosting while the segment pattern changes.
// Optional feature: define SEG_FLAG_BLINK_EN to blink the display while any
// flag is set (a BLINK_BITS-bit frame counter; its MSB blanks the anodes).
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 100000,
    parameter int GUARD      = 16,
    parameter int BLINK_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] shown16,
    input  logic [4:0]  flags,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [4:0]  led,
    output logic        frame_done
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] slot_cnt;
    digit_idx_t    idx;
    logic [15:0]   val_buf;
    logic [4:0]    flag_buf;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic          slot_wrap;
    logic          guard_on;
    logic          blink_off;
    logic          digit0_on;

    assign slot_wrap = (slot_cnt == CW'(CLK_DIV - 1));
    assign guard_on  = (slot_cnt < CW'(GUARD));
    assign nibble    = val_buf[{idx, 2'b00} +: 4];
    assign digit0_on = !blank && !guard_on && (idx == 2'd0);

    hex_to_7seg u_hex (
        .hex (nibble),
        .seg (seg_dec)
    );

`ifdef SEG_FLAG_BLINK_EN
    logic [BLINK_BITS-1:0] frame_cnt;

    // Count completed frames; the MSB gives a slow blink phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt <= '0;
        else if (frame_done)
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign blink_off = (flag_buf != 5'd0) && frame_cnt[BLINK_BITS-1];
`else
    // No frame counter in this build, so the display never blinks; any legal
    // BLINK_BITS (>= 1) makes this term constant 0.
    assign blink_off = (BLINK_BITS < 1);
`endif

    // Scan counters and display buffer; a load on a wrap edge is already
    // visible when the new digit's outputs are registered one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            val_buf  <= '0;
            flag_buf <= '0;
        end else begin
            if (load) begin
                val_buf  <= shown16;
                flag_buf <= flags;
            end
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                idx <= idx + 1'b1;
        end
    end

    // Registered outputs, one cycle behind the counter/index/buffer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            led        <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= (blank || guard_on || blink_off) ? AN_OFF : ~(4'b0001 << idx);
            seg        <= seg_dec;
            dp         <= ~(digit0_on && (flag_buf != 5'd0));
            led        <= flag_buf;
            frame_done <= slot_wrap && (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver (CLK_DIV=8, GUARD=2, BLINK_BITS=2).
// The reference model derives slot, digit and frame from the number of clock
// edges since reset release and keeps its own copy of the display buffer.
module tb_seg_display_driver;

    localparam int CLK_DIV    = 8;
    localparam int GUARD      = 2;
    localparam int BLINK_BITS = 2;
    localparam int FRAME      = 4 * CLK_DIV;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [15:0] shown16 = '0;
    logic [4:0]  flags   = '0;
    logic        load    = 1'b0;
    logic        blank   = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [4:0]  led;
    logic        frame_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n       = 0;
    logic [15:0] m_val   = '0;
    logic [4:0]  m_flag  = '0;
    logic [6:0]  seg_tbl [16];

    seg_display_driver #(
        .CLK_DIV    (CLK_DIV),
        .GUARD      (GUARD),
        .BLINK_BITS (BLINK_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .shown16    (shown16),
        .flags      (flags),
        .load       (load),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .led        (led),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // One clock edge: predict outputs from pre-edge state, update the model
    // buffer, then compare on the following falling edge.
    task automatic step();
        int         slot, digit, frame;
        logic       lit, an_lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        logic [4:0] e_led;
        @(posedge clk);
        slot   = n % CLK_DIV;
        digit  = (n / CLK_DIV) % 4;
        frame  = n / FRAME;
        lit    = !blank && (slot >= GUARD);
        an_lit = lit;
`ifdef SEG_FLAG_BLINK_EN
        if (m_flag != 0 && (frame % (1 << BLINK_BITS)) >= (1 << (BLINK_BITS - 1)))
            an_lit = 1'b0;
`endif
        e_an = 4'hF;
        if (an_lit) e_an[digit] = 1'b0;
        e_seg = seg_tbl[(m_val >> (4 * digit)) & 16'hF];
        e_dp  = !(lit && digit == 0 && m_flag != 0);
        e_led = m_flag;
        e_fd  = (n % FRAME) == FRAME - 1;
        if (load) begin
            m_val  = shown16;
            m_flag = flags;
        end
        n++;
        @(negedge clk);
        chk("an",         32'(an),         32'(e_an));
        chk("seg",        32'(seg),        32'(e_seg));
        chk("dp",         32'(dp),         32'(e_dp));
        chk("led",        32'(led),        32'(e_led));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Advance until the next edge is at position 'target' within the frame.
    task automatic wait_to(input int target);
        for (int i = 0; i < FRAME; i++) begin
            if ((n % FRAME) == target) break;
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},  32'(an),         32'(4'b1111));
        chk({tag, "_seg"}, 32'(seg),        32'(7'b1111111));
        chk({tag, "_dp"},  32'(dp),         32'(1'b1));
        chk({tag, "_led"}, 32'(led),        32'(5'b00000));
        chk({tag, "_fd"},  32'(frame_done), 32'(1'b0));
    endtask

    // Asserts reset asynchronously at a falling edge, holds it 3 cycles and
    // releases it; the model restarts at edge 0 with an empty buffer.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        reset  = 1'b1;
        n      = 0;
        m_val  = '0;
        m_flag = '0;
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        @(negedge clk);
        do_reset();
        run(12);

        // Decode of 12AF across a full frame, no flags.
        shown16 = 16'h12AF; flags = 5'd0; load = 1'b1;
        step();
        load = 1'b0;
        run(40);

        // Load coinciding with the 3->0 wrap.
        wait_to(FRAME - 1);
        shown16 = 16'h000F; load = 1'b1;
        step();
        load = 1'b0;
        run(12);

        // Blank raised mid digit 1, then released.
        wait_to(CLK_DIV + 4);
        blank = 1'b1;
        run(6);
        blank = 1'b0;
        run(40);

        // Single flag: LED, decimal point on digit 0 and (optionally) blink.
        shown16 = 16'h4321; flags = 5'b00001; load = 1'b1;
        step();
        load = 1'b0;
        run(4 * FRAME + 8);

        // Load held high with changing data.
        load = 1'b1;
        for (int i = 0; i < 12; i++) begin
            shown16 = 16'($urandom);
            flags   = 5'($urandom);
            step();
        end
        load = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 900; i++) begin
            load    = ($urandom % 6) == 0;
            shown16 = 16'($urandom);
            flags   = ($urandom % 2) ? 5'($urandom) : 5'd0;
            if (($urandom % 20) == 0) blank = ~blank;
            step();
        end
        load  = 1'b0;
        blank = 1'b0;

        // Reset in the middle of a slot aborts the scan.
        wait_to(2 * CLK_DIV + 5);
        do_reset();
        run(FRAME + 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
